// File: rtl/timetagging_buffer_sequencer_pkg.sv
// Shared types for the timetagging buffer sequencer: command layout, opcodes and FSM states.
package buffer_pkg;

  localparam int BANKING_MODE_WIDTH = 2;
  localparam int CMD_WIDTH          = 3 + BANKING_MODE_WIDTH;

  typedef enum logic [1:0] {
    OP_START   = 2'd0,
    OP_STOP    = 2'd1,
    OP_ABORT   = 2'd2,
    OP_READOUT = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STOP    = 3'd4,
    ST_DEPTH   = 3'd5,
    ST_READOUT = 3'd6,
    ST_ABORT   = 3'd7
  } state_e;

  typedef struct packed {
    logic [BANKING_MODE_WIDTH-1:0] bank;
    logic                          hw_start;
    opcode_e                       opcode;
  } cmd_t;

endpackage

// File: rtl/timetagging_buffer_sequencer_if.sv
// Single-beat valid/ready stream used for commands and buffer configuration.
interface Axis_If
  import buffer_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/timetagging_buffer_sequencer_xfer.sv
// One-beat stream master: captures data on a load strobe and holds it until the handshake.
module axis_single_xfer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  Axis_If.master           m,
  output logic             o_busy,
  output logic             o_done
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (r_valid && m.ready) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign m.valid = r_valid;
  assign m.data  = r_data;
  assign o_busy  = r_valid;
  assign o_done  = r_valid & m.ready;
endmodule

// File: rtl/timetagging_buffer_sequencer.sv
// Sequences capture/readout of the timetagging sample buffer from host commands.
// Define SEQUENCER_TIMEOUT_EN to compile in the CAPTURE timeout and ps_error[0].
module timetagging_buffer_sequencer
  import buffer_pkg::*;
#(
  parameter int CAPTURE_TIMEOUT     = 65536,
  parameter int READOUT_BEATS_MAX   = 4096,
  parameter int CHANNELS            = 2,
  parameter int SAMPLE_BUFFER_DEPTH = 1024,
  localparam int DEPTH_W = CHANNELS * ($clog2(SAMPLE_BUFFER_DEPTH) + 1)
) (
  input  logic               ps_clk,
  input  logic               ps_reset,
  Axis_If.slave              ps_cmd,
  Axis_If.master             ps_capture_arm_start_stop,
  Axis_If.master             ps_capture_banking_mode,
  Axis_If.master             ps_capture_sw_reset,
  Axis_If.master             ps_readout_sw_reset,
  Axis_If.master             ps_readout_start,
  Axis_If.slave              ps_samples_write_depth,
  input  logic [2:0]         ps_readout_monitor,
  output logic [2:0]         ps_state,
  output logic               ps_busy,
  output logic [1:0]         ps_error,
  output logic [DEPTH_W-1:0] ps_depth_diag
);
  localparam int RB_W = $clog2(READOUT_BEATS_MAX) + 1;
  localparam logic [RB_W-1:0] RB_MAX = RB_W'(READOUT_BEATS_MAX);

  state_e                        r_state;
  logic                          r_cmd_ready;
  logic                          r_hw_start;
  logic [BANKING_MODE_WIDTH-1:0] r_bank;
  logic [RB_W-1:0]               r_rd_cnt;
  logic                          r_err_ro;
  logic [DEPTH_W-1:0]            r_depth_diag;
  logic r_load_bank, r_load_ass, r_load_csr, r_load_rsr, r_load_rs;

  cmd_t       w_cmd;
  logic       w_cmd_fire, w_mon_beat, w_rs_pending;
  logic [2:0] w_ass_data;
  logic       w_bank_done, w_ass_done, w_csr_done, w_rsr_done, w_rs_done, w_rs_busy;
  logic       w_bank_busy, w_ass_busy, w_csr_busy, w_rsr_busy;
  logic [RB_W-1:0] w_rd_cnt_nxt;

`ifdef SEQUENCER_TIMEOUT_EN
  localparam int TO_W = $clog2(CAPTURE_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CAPTURE_TIMEOUT - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_to;
`endif

  assign w_cmd        = cmd_t'(ps_cmd.data);
  assign w_cmd_fire   = ps_cmd.valid & r_cmd_ready;
  assign w_mon_beat   = ps_readout_monitor[2] & ps_readout_monitor[1];
  // Monitor beats only count once readout_start has been handed off.
  assign w_rs_pending = r_load_rs | w_rs_busy;
  assign w_rd_cnt_nxt = r_rd_cnt + RB_W'(1);
  assign w_ass_data   = (r_state == ST_STOP) ? 3'b100 : {1'b0, ~r_hw_start, 1'b1};

  always_ff @(posedge ps_clk) begin
    if (ps_reset) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_hw_start   <= 1'b0;
      r_bank       <= '0;
      r_rd_cnt     <= '0;
      r_err_ro     <= 1'b0;
      r_depth_diag <= '0;
      r_load_bank  <= 1'b0;
      r_load_ass   <= 1'b0;
      r_load_csr   <= 1'b0;
      r_load_rsr   <= 1'b0;
      r_load_rs    <= 1'b0;
`ifdef SEQUENCER_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_err_to     <= 1'b0;
`endif
    end else begin
      r_load_bank <= 1'b0;
      r_load_ass  <= 1'b0;
      r_load_csr  <= 1'b0;
      r_load_rsr  <= 1'b0;
      r_load_rs   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            case (w_cmd.opcode)
              OP_START: begin
                r_hw_start  <= w_cmd.hw_start;
                r_bank      <= w_cmd.bank;
                r_err_ro    <= 1'b0;
`ifdef SEQUENCER_TIMEOUT_EN
                r_err_to    <= 1'b0;
`endif
                r_load_bank <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_state     <= ST_CONFIG;
              end
              OP_READOUT: begin
                r_rd_cnt    <= '0;
                r_load_rs   <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_state     <= ST_READOUT;
              end
              default: ;
            endcase
          end
        end
        ST_CONFIG: begin
          if (w_bank_done) begin
            r_load_ass <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_ass_done) begin
`ifdef SEQUENCER_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
            r_cmd_ready <= 1'b1;
            r_state     <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Host commands win over a timeout landing in the same cycle.
          if (w_cmd_fire && w_cmd.opcode == OP_ABORT) begin
            r_load_csr  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ABORT;
          end else if (w_cmd_fire && w_cmd.opcode == OP_STOP) begin
            r_load_ass  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_STOP;
          end
`ifdef SEQUENCER_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_err_to    <= 1'b1;
            r_load_ass  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_STOP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        ST_STOP: begin
          if (w_ass_done) r_state <= ST_DEPTH;
        end
        ST_DEPTH: begin
          if (ps_samples_write_depth.valid) begin
            r_depth_diag <= ps_samples_write_depth.data;
            r_cmd_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_READOUT: begin
          if (!w_rs_pending && w_mon_beat) begin
            if (ps_readout_monitor[0]) begin
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_rd_cnt <= w_rd_cnt_nxt;
              if (w_rd_cnt_nxt == RB_MAX) begin
                r_err_ro   <= 1'b1;
                r_load_csr <= 1'b1;
                r_state    <= ST_ABORT;
              end
            end
          end
        end
        ST_ABORT: begin
          if (w_csr_done) r_load_rsr <= 1'b1;
          if (w_rsr_done) begin
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign ps_cmd.ready                 = r_cmd_ready;
  assign ps_samples_write_depth.ready = 1'b1;
  assign ps_state                     = r_state;
  assign ps_busy                      = (r_state != ST_IDLE);
  assign ps_depth_diag                = r_depth_diag;
`ifdef SEQUENCER_TIMEOUT_EN
  assign ps_error = {r_err_ro, r_err_to};
`else
  assign ps_error = {r_err_ro, 1'b0};
`endif

  axis_single_xfer #(.WIDTH(BANKING_MODE_WIDTH)) u_bank (
    .clk(ps_clk), .reset(ps_reset), .i_load(r_load_bank), .i_data(r_bank),
    .m(ps_capture_banking_mode), .o_busy(w_bank_busy), .o_done(w_bank_done));

  axis_single_xfer #(.WIDTH(3)) u_ass (
    .clk(ps_clk), .reset(ps_reset), .i_load(r_load_ass), .i_data(w_ass_data),
    .m(ps_capture_arm_start_stop), .o_busy(w_ass_busy), .o_done(w_ass_done));

  axis_single_xfer #(.WIDTH(1)) u_csr (
    .clk(ps_clk), .reset(ps_reset), .i_load(r_load_csr), .i_data(1'b1),
    .m(ps_capture_sw_reset), .o_busy(w_csr_busy), .o_done(w_csr_done));

  axis_single_xfer #(.WIDTH(1)) u_rsr (
    .clk(ps_clk), .reset(ps_reset), .i_load(r_load_rsr), .i_data(1'b1),
    .m(ps_readout_sw_reset), .o_busy(w_rsr_busy), .o_done(w_rsr_done));

  axis_single_xfer #(.WIDTH(1)) u_rs (
    .clk(ps_clk), .reset(ps_reset), .i_load(r_load_rs), .i_data(1'b1),
    .m(ps_readout_start), .o_busy(w_rs_busy), .o_done(w_rs_done));

  // Only the readout_start busy flag gates anything; the other flags are kept for symmetry.
  logic w_unused;
  assign w_unused = w_bank_busy ^ w_ass_busy ^ w_csr_busy ^ w_rsr_busy ^ w_rs_done;
endmodule

// File: tb/tb_timetagging_buffer_sequencer.sv
// Directed bench for timetagging_buffer_sequencer (CAPTURE_TIMEOUT=64, READOUT_BEATS_MAX=16).
module tb_timetagging_buffer_sequencer;
  import buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mon;
  logic [2:0]  st;
  logic        busy;
  logic [1:0]  err;
  logic [21:0] diag;
  int          checks = 0;
  int          errors = 0;
  int          n;
  int          rs_seen;

  localparam int CH_BANK = 0, CH_ASS = 1, CH_CSR = 2, CH_RSR = 3, CH_RS = 4;
`ifdef SEQUENCER_TIMEOUT_EN
  localparam int STOP_WAIT = 40;
`else
  localparam int STOP_WAIT = 100;
`endif

  Axis_If #(.WIDTH(5))  cmd_if ();
  Axis_If #(.WIDTH(3))  ass_if ();
  Axis_If #(.WIDTH(2))  bank_if ();
  Axis_If #(.WIDTH(1))  csr_if ();
  Axis_If #(.WIDTH(1))  rsr_if ();
  Axis_If #(.WIDTH(1))  rs_if ();
  Axis_If #(.WIDTH(22)) depth_if ();

  timetagging_buffer_sequencer #(
    .CAPTURE_TIMEOUT(64), .READOUT_BEATS_MAX(16), .CHANNELS(2), .SAMPLE_BUFFER_DEPTH(1024)
  ) dut (
    .ps_clk(clk), .ps_reset(rst), .ps_cmd(cmd_if),
    .ps_capture_arm_start_stop(ass_if), .ps_capture_banking_mode(bank_if),
    .ps_capture_sw_reset(csr_if), .ps_readout_sw_reset(rsr_if), .ps_readout_start(rs_if),
    .ps_samples_write_depth(depth_if), .ps_readout_monitor(mon),
    .ps_state(st), .ps_busy(busy), .ps_error(err), .ps_depth_diag(diag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ch_valid(input int ch);
    case (ch)
      CH_BANK: return bank_if.valid;
      CH_ASS:  return ass_if.valid;
      CH_CSR:  return csr_if.valid;
      CH_RSR:  return rsr_if.valid;
      CH_RS:   return rs_if.valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ch_data(input int ch);
    case (ch)
      CH_BANK: return 32'(bank_if.data);
      CH_ASS:  return 32'(ass_if.data);
      CH_CSR:  return 32'(csr_if.data);
      CH_RSR:  return 32'(rsr_if.data);
      CH_RS:   return 32'(rs_if.data);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] all_valids();
    return {bank_if.valid, ass_if.valid, csr_if.valid, rsr_if.valid, rs_if.valid};
  endfunction

  task automatic send_cmd(input opcode_e op, input logic hw, input logic [1:0] bank);
    int k = 0;
    cmd_if.data  = {bank, hw, op};
    cmd_if.valid = 1'b1;
    while (!cmd_if.ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready", 32'(cmd_if.ready), 32'd1);
    tick();
    cmd_if.valid = 1'b0;
  endtask

  // Requires the channel's ready to be high: the beat is taken on the next edge.
  task automatic wait_xfer(input int ch, input logic [31:0] exp, input string tag);
    int k = 0;
    while (!ch_valid(ch) && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(ch_valid(ch)), 32'd1);
    check({tag, "_data"}, ch_data(ch), exp);
    tick();
    check({tag, "_drop"}, 32'(ch_valid(ch)), 32'd0);
  endtask

  task automatic beat(input logic v, input logic r, input logic l);
    mon = {v, r, l};
    tick();
    mon = 3'b000;
  endtask

  task automatic start_capture(input logic hw, input logic [1:0] bank, input logic [2:0] exp_ass);
    send_cmd(OP_START, hw, bank);
    wait_xfer(CH_BANK, 32'(bank), "bank");
    wait_xfer(CH_ASS, 32'(exp_ass), "arm");
    check("in_capture", 32'(st), 32'(ST_CAPTURE));
  endtask

  task automatic drain_abort(input string tag);
    wait_xfer(CH_CSR, 32'd1, {tag, "_csr"});
    check({tag, "_rsr_after_csr"}, 32'(rsr_if.valid), 32'd0);
    wait_xfer(CH_RSR, 32'd1, {tag, "_rsr"});
    check({tag, "_idle"}, 32'(st), 32'(ST_IDLE));
  endtask

  initial begin
    cmd_if.valid = 1'b0;  cmd_if.data = '0;
    ass_if.ready = 1'b1;  bank_if.ready = 1'b1;
    csr_if.ready = 1'b1;  rsr_if.ready = 1'b1;  rs_if.ready = 1'b1;
    depth_if.valid = 1'b0; depth_if.data = '0;
    mon = 3'b000;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(st), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(err), 32'd0);
    check("rst_valids", 32'(all_valids()), 32'd0);
    check("rst_cmd_ready", 32'(cmd_if.ready), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_if.ready), 32'd1);

    // STOP and ABORT in IDLE are swallowed.
    send_cmd(OP_STOP, 1'b0, 2'd0);
    send_cmd(OP_ABORT, 1'b0, 2'd0);
    tick();
    check("idle_ignore_state", 32'(st), 32'(ST_IDLE));
    check("idle_ignore_valids", 32'(all_valids()), 32'd0);

    // Normal capture: bank=1, software start.
    start_capture(1'b0, 2'd1, 3'b011);
    check("capture_busy", 32'(busy), 32'd1);
    repeat (STOP_WAIT) tick();
    check("capture_hold", 32'(st), 32'(ST_CAPTURE));
    send_cmd(OP_STOP, 1'b0, 2'd0);
    wait_xfer(CH_ASS, 32'h4, "stop");
    check("in_depth", 32'(st), 32'(ST_DEPTH));
    depth_if.data  = 22'h2A5A5;
    depth_if.valid = 1'b1;
    tick();
    depth_if.valid = 1'b0;
    check("depth_idle", 32'(st), 32'(ST_IDLE));
    check("depth_busy", 32'(busy), 32'd0);
    check("depth_error", 32'(err), 32'd0);
    check("depth_diag", 32'(diag), 32'h2A5A5);

    // Readout terminated by last on beat 10, with a stalled beat mixed in.
    send_cmd(OP_READOUT, 1'b0, 2'd0);
    check("in_readout", 32'(st), 32'(ST_READOUT));
    wait_xfer(CH_RS, 32'd1, "rd_start");
    rs_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b1, (i == 10));
      if (rs_if.valid) rs_seen++;
      if (i == 9) check("rd_before_last", 32'(st), 32'(ST_READOUT));
    end
    check("rd_after_last", 32'(st), 32'(ST_IDLE));
    check("rd_start_once", 32'(rs_seen), 32'd0);

    // Readout overrun: 16 beats without last.
    send_cmd(OP_READOUT, 1'b0, 2'd0);
    wait_xfer(CH_RS, 32'd1, "ro_start");
    for (int i = 1; i <= 15; i++) begin
      if (i == 7) beat(1'b0, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 1'b0);
    end
    check("ro_beat15_state", 32'(st), 32'(ST_READOUT));
    check("ro_beat15_error", 32'(err), 32'd0);
    beat(1'b1, 1'b1, 1'b0);
    check("ro_abort_state", 32'(st), 32'(ST_ABORT));
    check("ro_error", 32'(err), 32'h2);
    drain_abort("ro");
    check("ro_error_sticky", 32'(err), 32'h2);

    // hw_start capture, then ABORT with capture_sw_reset stalled for 5 cycles.
    start_capture(1'b1, 2'd2, 3'b001);
    check("start_clears_error", 32'(err), 32'd0);
    csr_if.ready = 1'b0;
    send_cmd(OP_ABORT, 1'b0, 2'd0);
    check("ab_state", 32'(st), 32'(ST_ABORT));
    n = 0;
    while (!csr_if.valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("ab_csr_held", 32'(csr_if.valid), 32'd1);
      check("ab_no_stop", 32'(ass_if.valid), 32'd0);
      tick();
    end
    csr_if.ready = 1'b1;
    drain_abort("ab");
    check("ab_valids", 32'(all_valids()), 32'd0);

`ifdef SEQUENCER_TIMEOUT_EN
    start_capture(1'b0, 2'd0, 3'b011);
    n = 0;
    while (st == ST_CAPTURE && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_state", 32'(st), 32'(ST_STOP));
    check("to_error", 32'(err), 32'h1);
    wait_xfer(CH_ASS, 32'h4, "to_stop");
    depth_if.valid = 1'b1;
    tick();
    depth_if.valid = 1'b0;
    check("to_idle", 32'(st), 32'(ST_IDLE));

    // ABORT lands on the same edge as the timeout.
    start_capture(1'b0, 2'd0, 3'b011);
    check("to_start_clears", 32'(err), 32'd0);
    repeat (63) tick();
    send_cmd(OP_ABORT, 1'b0, 2'd0);
    check("to_abort_priority", 32'(st), 32'(ST_ABORT));
    drain_abort("tp");
`else
    start_capture(1'b0, 2'd0, 3'b011);
    repeat (1000) tick();
    check("no_timeout_state", 32'(st), 32'(ST_CAPTURE));
    check("no_timeout_error", 32'(err), 32'd0);
    send_cmd(OP_ABORT, 1'b0, 2'd0);
    drain_abort("nt");
`endif

    // Reset in the middle of an ABORT transaction drops it.
    start_capture(1'b0, 2'd3, 3'b011);
    csr_if.ready = 1'b0;
    send_cmd(OP_ABORT, 1'b0, 2'd0);
    repeat (3) tick();
    check("mid_csr_pending", 32'(csr_if.valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 32'(st), 32'(ST_IDLE));
    check("mid_rst_valids", 32'(all_valids()), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_if.ready), 32'd0);
    rst = 1'b0;
    csr_if.ready = 1'b1;
    tick();
    check("mid_post_cmd_ready", 32'(cmd_if.ready), 32'd1);
    repeat (3) tick();
    check("mid_post_valids", 32'(all_valids()), 32'd0);
    check("mid_post_state", 32'(st), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
